// File: rtl/aes_dec_axil_ctrl.sv
// aes_dec_axil_ctrl: AXI4-Lite register front end feeding the AES-128 decrypt core.
// Define AES_DEC_TIMEOUT_EN to build the WAIT-state watchdog (STATUS.TIMEOUT).
module aes_dec_axil_ctrl #(
    parameter int C_ADDR_WIDTH   = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [C_ADDR_WIDTH-1:0] AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [C_ADDR_WIDTH-1:0] ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [127:0]            core_key,
    output logic [127:0]            core_ct,
    output logic                    core_start,
    input  logic                    core_ready,
    input  logic [127:0]            core_pt,
    input  logic                    core_done,
    output logic                    irq
);
    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
    state_t state, state_nx;
    logic [31:0] key [4];
    logic [31:0] ct [4];
    logic [31:0] pt [4];
    logic [31:0] rd_val;
    logic [3:0] wa, ra;
    logic irq_en, done, timeout, to_hit, busy, wr, rd, hi_w, hi_r;
    logic wr_key, wr_ct, wr_ctl, wr_sts, go, bad, unused;

    assign busy   = state != IDLE;
    assign wr     = AWREADY & AWVALID & WVALID;
    assign rd     = ARREADY & ARVALID;
    assign wa     = AWADDR[5:2];
    assign ra     = ARADDR[5:2];
    assign hi_w   = |(AWADDR >> 6);
    assign hi_r   = |(ARADDR >> 6);
    assign wr_key = wr & ~hi_w & (wa[3:2] == 2'b01);
    assign wr_ct  = wr & ~hi_w & (wa[3:2] == 2'b10);
    assign wr_ctl = wr & ~hi_w & (wa == 4'd0) & WSTRB[0];
    assign wr_sts = wr & ~hi_w & (wa == 4'd1) & WSTRB[0];
    assign go     = wr_ctl & WDATA[0] & ~busy;
    assign bad    = busy & (wr_key | wr_ct | (wr_ctl & WDATA[0]));
    assign unused = ^{AWADDR[1:0], ARADDR[1:0]};

    assign RRESP    = 2'b00;
    assign core_key = {key[0], key[1], key[2], key[3]};
    assign core_ct  = {ct[0], ct[1], ct[2], ct[3]};
    assign irq      = irq_en & (done | timeout);

    always_comb begin
        state_nx   = state;
        core_start = state == START;
        state_nx   = (state == IDLE && go) ? START :
                     (state == START && core_ready) ? WAIT :
                     (state == WAIT && (core_done || to_hit)) ? IDLE : state;
    end

    assign rd_val = hi_r ? 32'd0 :
                    ra == 4'd0 ? {30'd0, irq_en, 1'b0} :
                    ra == 4'd1 ? {29'd0, timeout, done, busy} :
                    ra[3:2] == 2'b01 ? key[ra[1:0]] :
                    ra[3:2] == 2'b10 ? ct[ra[1:0]] :
                    ra[3:2] == 2'b11 ? pt[ra[1:0]] : 32'd0;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= 2'b00;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= 32'd0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                key[i] <= 32'd0;
                ct[i]  <= 32'd0;
                pt[i]  <= 32'd0;
            end
        end else begin
            state   <= state_nx;
            AWREADY <= AWVALID & WVALID & ~AWREADY & ~BVALID;
            WREADY  <= AWVALID & WVALID & ~AWREADY & ~BVALID;
            BVALID  <= wr | (BVALID & ~BREADY);
            ARREADY <= ARVALID & ~ARREADY & ~RVALID;
            RVALID  <= rd | (RVALID & ~RREADY);
            if (wr) BRESP <= bad ? 2'b10 : 2'b00;
            if (rd) RDATA <= rd_val;
            if (wr_ctl) irq_en <= WDATA[1];
            if (go || (wr_sts && WDATA[1])) done <= 1'b0;
            // a completing operation beats a same-cycle W1C of DONE
            if (state == WAIT && core_done) begin
                done <= 1'b1;
                for (int i = 0; i < 4; i++) pt[i] <= core_pt[127-32*i -: 32];
            end
            for (int i = 0; i < 4; i++)
                for (int b = 0; b < 4; b++) begin
                    if (!busy && wr_key && wa[1:0] == 2'(i) && WSTRB[b]) key[i][8*b +: 8] <= WDATA[8*b +: 8];
                    if (!busy && wr_ct && wa[1:0] == 2'(i) && WSTRB[b]) ct[i][8*b +: 8] <= WDATA[8*b +: 8];
                end
        end
    end

`ifdef AES_DEC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign to_hit = state == WAIT && !core_done && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (wr_sts && WDATA[2]) timeout <= 1'b0;
            if (to_hit) timeout <= 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule
